// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> DONE, one memory access per three cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                winner_reg, winner_next;
    logic                pick_p1;

`ifdef DMEM_ARB_RR_EN
    // Reset value 1 makes port 0 the first winner of a tie.
    logic                last_grant_reg;

    assign pick_p1 = p1_req && (!p0_req || !last_grant_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (state_reg == IDLE && (p0_req || p1_req)) begin
            last_grant_reg <= pick_p1;
        end
    end
`else
    assign pick_p1 = p1_req && !p0_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            winner_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            rdata_reg  <= rdata_next;
            winner_reg <= winner_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        we_next     = we_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        rdata_next  = rdata_reg;
        winner_next = winner_reg;
        case (state_reg)
            IDLE: begin
                if (p0_req || p1_req) begin
                    winner_next = pick_p1;
                    we_next     = pick_p1 ? p1_we    : p0_we;
                    addr_next   = pick_p1 ? p1_addr  : p0_addr;
                    wdata_next  = pick_p1 ? p1_wdata : p0_wdata;
                    state_next  = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_reg) begin
                    rdata_next = mem_read_data;
                end
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address and write data are driven from the latch at all times so the bus stays quiet between accesses.
    assign mem_address    = addr_reg;
    assign mem_write_data = wdata_reg;
    assign mem_read       = (state_reg == ACCESS) && !we_reg;
    assign mem_write      = (state_reg == ACCESS) && we_reg;
    assign busy           = (state_reg != IDLE);

    logic [1:0]        ack_vec;
    logic [DATA_W-1:0] rdata_vec [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign ack_vec[gi]   = (state_reg == DONE) && (winner_reg == 1'(gi));
        assign rdata_vec[gi] = (ack_vec[gi] && !we_reg) ? rdata_reg : '0;
    end

    assign p0_ack   = ack_vec[0];
    assign p1_ack   = ack_vec[1];
    assign p0_rdata = rdata_vec[0];
    assign p1_rdata = rdata_vec[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory whose unwritten words read a fixed address pattern.
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 48;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_ack, p1_ack;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read, mem_write;
    logic [DATA_W-1:0] mem_read_data;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wr_base;

    logic [DATA_W-1:0] mem     [0:1023];
    bit                written [0:1023];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .p0_req         (p0_req),
        .p0_we          (p0_we),
        .p0_addr        (p0_addr),
        .p0_wdata       (p0_wdata),
        .p0_ack         (p0_ack),
        .p0_rdata       (p0_rdata),
        .p1_req         (p1_req),
        .p1_we          (p1_we),
        .p1_addr        (p1_addr),
        .p1_wdata       (p1_wdata),
        .p1_ack         (p1_ack),
        .p1_rdata       (p1_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_address]     <= mem_write_data;
            written[mem_address] <= 1'b1;
            wr_cnt               <= wr_cnt + 1;
        end
    end

    assign mem_read_data = written[mem_address] ? mem[mem_address] : {16'hA5A5, 22'd0, mem_address};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_w;
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_p0_ack", p0_ack, 0);
        check("rst_p1_ack", p1_ack, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        rst_n = 1'b1;

        // Port 0 write 0x2A to 0x005
        wr_base = wr_cnt;
        p0_req = 1; p0_we = 1; p0_addr = 10'h005; p0_wdata = 48'h0000_0000_002A;
        @(negedge clk);
        check("wr_access_busy", busy, 1);
        check("wr_access_mem_write", mem_write, 1);
        check("wr_access_mem_read", mem_read, 0);
        check("wr_access_addr", mem_address, 10'h005);
        check("wr_access_wdata", mem_write_data, 48'h2A);
        check("wr_access_p0_ack", p0_ack, 0);
        @(negedge clk);
        check("wr_done_p0_ack", p0_ack, 1);
        check("wr_done_p0_rdata", p0_rdata, 0);
        check("wr_done_p1_ack", p1_ack, 0);
        check("wr_done_mem_write", mem_write, 0);
        p0_req = 0;
        @(negedge clk);
        check("wr_idle_busy", busy, 0);
        check("wr_idle_p0_ack", p0_ack, 0);
        check("wr_strobe_cycles", wr_cnt - wr_base, 1);
        check("wr_idle_addr_hold", mem_address, 10'h005);

        // Port 0 read back 0x005
        p0_req = 1; p0_we = 0; p0_wdata = '0;
        @(negedge clk);
        check("rd_access_mem_read", mem_read, 1);
        check("rd_access_mem_write", mem_write, 0);
        check("rd_access_p0_ack", p0_ack, 0);
        @(negedge clk);
        check("rd_done_p0_ack", p0_ack, 1);
        check("rd_done_p0_rdata", p0_rdata, 48'h2A);
        p0_req = 0;
        @(negedge clk);
        check("rd_idle_p0_ack", p0_ack, 0);
        check("rd_idle_p0_rdata", p0_rdata, 0);

        // Port 1 alone reads 0x3FF, address changes after the latch edge
        p1_req = 1; p1_we = 0; p1_addr = 10'h3FF;
        @(negedge clk);
        check("p1_access_addr", mem_address, 10'h3FF);
        check("p1_access_mem_read", mem_read, 1);
        check("p1_access_p0_ack", p0_ack, 0);
        p1_addr = 10'h000;
        @(negedge clk);
        check("p1_done_addr", mem_address, 10'h3FF);
        check("p1_done_p1_ack", p1_ack, 1);
        check("p1_done_p1_rdata", p1_rdata, 48'hA5A5_0000_03FF);
        check("p1_done_p0_ack", p0_ack, 0);
        p1_req = 0;
        @(negedge clk);
        check("p1_idle_p1_ack", p1_ack, 0);
        check("p1_idle_p1_rdata", p1_rdata, 0);

        // Both ports request continuously from reset
        rst_n = 1'b0;
        p0_req = 1; p0_we = 0; p0_addr = 10'h010;
        p1_req = 1; p1_we = 0; p1_addr = 10'h020;
        @(negedge clk);
        check("tie_rst_busy", busy, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
            exp_w = k % 2;
`else
            exp_w = 0;
`endif
            @(negedge clk);
            check($sformatf("tie%0d_busy", k), busy, 1);
            check($sformatf("tie%0d_addr", k), mem_address, (exp_w == 1) ? 10'h020 : 10'h010);
            check($sformatf("tie%0d_early_ack", k), {p1_ack, p0_ack}, 0);
            @(negedge clk);
            check($sformatf("tie%0d_p0_ack", k), p0_ack, (exp_w == 0) ? 1 : 0);
            check($sformatf("tie%0d_p1_ack", k), p1_ack, (exp_w == 1) ? 1 : 0);
            check($sformatf("tie%0d_rdata", k), (exp_w == 1) ? p1_rdata : p0_rdata,
                  (exp_w == 1) ? 48'hA5A5_0000_0020 : 48'hA5A5_0000_0010);
            @(negedge clk);
            check($sformatf("tie%0d_idle", k), busy, 0);
        end
        p0_req = 0; p1_req = 0;

        // Reset during the ACCESS cycle of a write aborts it
        p0_req = 1; p0_we = 1; p0_addr = 10'h007; p0_wdata = 48'h55;
        @(negedge clk);
        check("abort_access_mem_write", mem_write, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_mem_write", mem_write, 0);
        check("abort_busy", busy, 0);
        check("abort_addr_cleared", mem_address, 0);
        p0_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort_post%0d_acks", k), {p1_ack, p0_ack}, 0);
            check($sformatf("abort_post%0d_busy", k), busy, 0);
        end
        check("abort_no_mem_write", written[7], 0);

        p0_req = 1; p0_we = 0; p0_addr = 10'h005;
        @(negedge clk);
        check("post_abort_mem_read", mem_read, 1);
        check("post_abort_addr", mem_address, 10'h005);
        @(negedge clk);
        check("post_abort_p0_ack", p0_ack, 1);
        check("post_abort_p0_rdata", p0_rdata, 48'h2A);
        p0_req = 0;
        @(negedge clk);
        check("post_abort_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
